// File: rtl/conbus_pkg.sv
// Shared definitions for the Wishbone interconnect slave bridges:
// CSR bridge state encoding and Wishbone cycle-type identifiers.
package conbus_pkg;

    // CSR bridge FSM state encoding
    localparam logic [2:0] CSRBRG_IDLE = 3'd0;
    localparam logic [2:0] CSRBRG_WR   = 3'd1;
    localparam logic [2:0] CSRBRG_RD1  = 3'd2;
    localparam logic [2:0] CSRBRG_RD2  = 3'd3;
    localparam logic [2:0] CSRBRG_ACK  = 3'd4;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // True when the current beat announces that another incrementing beat follows
    function automatic logic cti_continues(input logic [2:0] cti);
        return cti == CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_csr_bridge.sv
// Wishbone classic slave to synchronous CSR bus bridge.
// Writes take 2 cycles to ack, reads 3 (CSR read data is registered).
// Optional feature macro: CSRBRG_BURST_EN -- incrementing read bursts go
// ACK -> RD1 directly with csr_a + 1, skipping IDLE.
module wb_csr_bridge
    import conbus_pkg::*;
#(
    parameter int unsigned CSR_AW = 14
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [2:0]        wb_cti_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,

    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       access;
    logic       burst_more;

    // Byte lanes, cycle type (when bursts are off) and undecoded address bits are not used
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_cti_i, wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

    assign access = wb_cyc_i & wb_stb_i;

`ifdef CSRBRG_BURST_EN
    // Another read beat of an incrementing burst is being requested
    assign burst_more = cti_continues(wb_cti_i) & ~wb_we_i & access;
`else
    assign burst_more = 1'b0;
`endif

    // Next-state decode; a dropped cyc abandons the access without ack
    always_comb begin
        state_next = state;
        case (state)
            CSRBRG_IDLE: if (access) state_next = wb_we_i ? CSRBRG_WR : CSRBRG_RD1;
            CSRBRG_WR:   state_next = wb_cyc_i ? CSRBRG_ACK : CSRBRG_IDLE;
            CSRBRG_RD1:  state_next = wb_cyc_i ? CSRBRG_RD2 : CSRBRG_IDLE;
            CSRBRG_RD2:  state_next = wb_cyc_i ? CSRBRG_ACK : CSRBRG_IDLE;
            CSRBRG_ACK:  state_next = burst_more ? CSRBRG_RD1 : CSRBRG_IDLE;
            default:     state_next = CSRBRG_IDLE;
        endcase
    end

    // State, datapath capture and registered strobes (strobes mirror the state being entered)
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= CSRBRG_IDLE;
            wb_ack_o <= 1'b0;
            csr_we   <= 1'b0;
            csr_a    <= '0;
            csr_do   <= '0;
            wb_dat_o <= '0;
        end else begin
            state    <= state_next;
            wb_ack_o <= (state_next == CSRBRG_ACK);
            csr_we   <= (state_next == CSRBRG_WR);
            if ((state == CSRBRG_IDLE) && access) begin
                csr_a  <= wb_adr_i[CSR_AW+1:2];
                csr_do <= wb_dat_i;
            end
            if ((state == CSRBRG_ACK) && burst_more) begin
                csr_a <= csr_a + CSR_AW'(1);
            end
            if (state == CSRBRG_RD2) begin
                wb_dat_o <= csr_di;
            end
        end
    end

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Directed self-checking bench for wb_csr_bridge with a registered CSR read model.
module tb_wb_csr_bridge;
    import conbus_pkg::*;

    localparam int unsigned CSR_AW = 14;
`ifdef CSRBRG_BURST_EN
    localparam int BEAT_GAP = 3;
`else
    localparam int BEAT_GAP = 4;
`endif

    logic              sys_clk;
    logic              sys_rst;
    logic [31:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic [2:0]        wb_cti_i;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_ack_o;
    logic [CSR_AW-1:0] csr_a;
    logic              csr_we;
    logic [31:0]       csr_do;
    logic [31:0]       csr_di;

    int total = 0;
    int bad   = 0;

    wb_csr_bridge #(.CSR_AW(CSR_AW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_cti_i (wb_cti_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .csr_di   (csr_di)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // CSR register bank model: word 8 is a fixed ID, others echo their address
    function automatic logic [31:0] csr_model(input logic [CSR_AW-1:0] a);
        if (a == 14'd8) return 32'h1234_5678;
        return {16'hC5A0, 2'b00, a};
    endfunction

    // Read data is registered: valid one cycle after csr_a
    always @(posedge sys_clk) csr_di <= csr_model(csr_a);

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = CTI_CLASSIC;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        step();
        total++;
        if (wb_ack_o !== 1'b0 || csr_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes ack=%b we=%b required 0 0", wb_ack_o, csr_we);
        end
        total++;
        if (csr_a !== 14'd0 || csr_do !== 32'd0 || wb_dat_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_data csr_a=%h csr_do=%h dat_o=%h required all 0", csr_a, csr_do, wb_dat_o);
        end
        total++;
        if (dut.state !== CSRBRG_IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d required=%0d", dut.state, CSRBRG_IDLE);
        end
    endtask

    task automatic test_single_write();
        wb_adr_i = 32'h0000_0010;
        wb_dat_i = 32'hDEAD_BEEF;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();  // T1
        total++;
        if (csr_we !== 1'b1 || wb_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_t1 we=%b ack=%b required we=1 ack=0", csr_we, wb_ack_o);
        end
        total++;
        if (csr_a !== 14'd4 || csr_do !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL wr_payload csr_a=%h csr_do=%h required 0004 deadbeef", csr_a, csr_do);
        end
        step();  // T2
        total++;
        if (csr_we !== 1'b0 || wb_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL wr_t2 we=%b ack=%b required we=0 ack=1", csr_we, wb_ack_o);
        end
        idle_bus();
        step();  // T3
        total++;
        if (wb_ack_o !== 1'b0 || dut.state !== CSRBRG_IDLE) begin
            bad++;
            $display("FAIL wr_t3 ack=%b state=%0d required ack=0 state=0", wb_ack_o, dut.state);
        end
    endtask

    task automatic test_single_read();
        bit we_seen = 0;
        wb_adr_i = 32'h0000_0020;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();  // T1
        if (csr_we) we_seen = 1;
        total++;
        if (csr_a !== 14'd8 || wb_ack_o !== 1'b0 || dut.state !== CSRBRG_RD1) begin
            bad++;
            $display("FAIL rd_t1 csr_a=%h ack=%b state=%0d required 0008 0 %0d", csr_a, wb_ack_o, dut.state, CSRBRG_RD1);
        end
        step();  // T2
        if (csr_we) we_seen = 1;
        total++;
        if (wb_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_t2_ack got=%b required=0", wb_ack_o);
        end
        step();  // T3
        if (csr_we) we_seen = 1;
        total++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL rd_t3 ack=%b dat=%h required 1 12345678", wb_ack_o, wb_dat_o);
        end
        idle_bus();
        step();
        if (csr_we) we_seen = 1;
        total++;
        if (wb_ack_o !== 1'b0 || we_seen) begin
            bad++;
            $display("FAIL rd_end ack=%b we_seen=%0d required 0 0", wb_ack_o, we_seen);
        end
    endtask

    task automatic test_aborted_read();
        bit ack_seen = 0;
        wb_adr_i = 32'h0000_0030;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();  // T1, RD1
        step();  // T2, RD2
        total++;
        if (dut.state !== CSRBRG_RD2) begin
            bad++;
            $display("FAIL abort_in_rd2 state=%0d required=%0d", dut.state, CSRBRG_RD2);
        end
        idle_bus();
        step();  // T3
        if (wb_ack_o) ack_seen = 1;
        total++;
        if (dut.state !== CSRBRG_IDLE) begin
            bad++;
            $display("FAIL abort_state got=%0d required=%0d", dut.state, CSRBRG_IDLE);
        end
        step();
        if (wb_ack_o) ack_seen = 1;
        total++;
        if (ack_seen) begin
            bad++;
            $display("FAIL abort_ack got=1 required=0");
        end
        // follow-up write must complete normally
        wb_adr_i = 32'h0000_0044;
        wb_dat_i = 32'hA5A5_0F0F;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();
        total++;
        if (csr_we !== 1'b1 || csr_a !== 14'h0011 || csr_do !== 32'hA5A5_0F0F) begin
            bad++;
            $display("FAIL abort_wr_t1 we=%b csr_a=%h csr_do=%h required 1 0011 a5a50f0f", csr_we, csr_a, csr_do);
        end
        step();
        total++;
        if (wb_ack_o !== 1'b1 || csr_we !== 1'b0) begin
            bad++;
            $display("FAIL abort_wr_t2 ack=%b we=%b required 1 0", wb_ack_o, csr_we);
        end
        idle_bus();
        step();
    endtask

    task automatic test_reset_mid_write();
        bit late = 0;
        wb_adr_i = 32'h0000_0008;
        wb_dat_i = 32'h1111_2222;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        step();  // T1, in WR
        total++;
        if (csr_we !== 1'b1) begin
            bad++;
            $display("FAIL rstwr_we_before got=%b required=1", csr_we);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        total++;
        if (csr_we !== 1'b0 || wb_ack_o !== 1'b0 || dut.state !== CSRBRG_IDLE || csr_a !== 14'd0) begin
            bad++;
            $display("FAIL rstwr_async we=%b ack=%b state=%0d csr_a=%h required 0 0 0 0000",
                     csr_we, wb_ack_o, dut.state, csr_a);
        end
        idle_bus();
        step();
        sys_rst = 1'b0;
        repeat (4) begin
            step();
            if (wb_ack_o || csr_we) late = 1;
        end
        total++;
        if (late) begin
            bad++;
            $display("FAIL rstwr_late_ack got=1 required=0");
        end
    endtask

    task automatic test_back_to_back();
        logic [CSR_AW-1:0] exp_a [4];
        logic [31:0]       exp_d [4];
        logic [2:0]        ctis  [4];
        int  beat     = 0;
        int  cyc_n    = 0;
        int  last_ack = 0;
        bit  upd      = 0;
        bit  we_seen  = 0;
        exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
        exp_d[0] = 32'hC5A0_3FFE; exp_d[1] = 32'hC5A0_3FFF;
        exp_d[2] = 32'hC5A0_0000; exp_d[3] = 32'hC5A0_0001;
        ctis[0] = CTI_INCR; ctis[1] = CTI_INCR; ctis[2] = CTI_INCR; ctis[3] = CTI_END;
        wb_adr_i = 32'h0000_FFF8;
        wb_cti_i = ctis[0];
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        while (beat < 4 && cyc_n < 40) begin
            step();
            cyc_n++;
            if (upd) begin
                upd      = 0;
                wb_adr_i = wb_adr_i + 32'd4;
                wb_cti_i = ctis[beat];
            end
            if (csr_we) we_seen = 1;
            if (wb_ack_o) begin
                total++;
                if (csr_a !== exp_a[beat] || wb_dat_o !== exp_d[beat]) begin
                    bad++;
                    $display("FAIL burst_beat%0d csr_a=%h dat=%h required %h %h",
                             beat, csr_a, wb_dat_o, exp_a[beat], exp_d[beat]);
                end
                if (beat > 0) begin
                    total++;
                    if (cyc_n - last_ack != BEAT_GAP) begin
                        bad++;
                        $display("FAIL burst_gap%0d got=%0d required=%0d", beat, cyc_n - last_ack, BEAT_GAP);
                    end
                end
                last_ack = cyc_n;
                beat++;
                if (beat < 4) upd = 1;
            end
        end
        total++;
        if (beat != 4) begin
            bad++;
            $display("FAIL burst_timeout beats=%0d required=4", beat);
        end
        step();
        idle_bus();
        step();
        total++;
        if (dut.state !== CSRBRG_IDLE || wb_ack_o !== 1'b0 || we_seen) begin
            bad++;
            $display("FAIL burst_end state=%0d ack=%b we_seen=%0d required 0 0 0", dut.state, wb_ack_o, we_seen);
        end
    endtask

    initial begin
        sys_rst  = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = 4'hF;
        idle_bus();
        test_reset();
        test_single_write();
        test_single_read();
        test_aborted_read();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
